// File: rtl/ip_rewrite_cam_arb.sv
// Arbitrates one flow-lookup CAM between two rewriter read ports and the table write port,
// buffering each read result until its requester consumes it.
module ip_rewrite_cam_arb #(
    parameter int TABLE_ENTRIES = 8,
    parameter int TUPLE_W       = 96,
    parameter int ADDR_W        = 32,
    parameter int WR_STREAK_MAX = 4,
    localparam int ENT_W        = $clog2(TABLE_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               rd_req_val,
    input  logic [2*TUPLE_W-1:0]     rd_req_tuple,
    output logic [1:0]               rd_req_rdy,
    output logic [1:0]               rd_resp_val,
    output logic [1:0]               rd_resp_hit,
    output logic [2*ADDR_W-1:0]      rd_resp_addr,
    input  logic [1:0]               rd_resp_rdy,
    input  logic                     wr_req_val,
    input  logic [ENT_W-1:0]         wr_req_entry,
    input  logic                     wr_req_set,
    input  logic [TUPLE_W-1:0]       wr_req_tuple,
    input  logic [ADDR_W-1:0]        wr_req_addr,
    output logic                     wr_req_rdy,
    output logic [TABLE_ENTRIES-1:0] cam_w_v,
    output logic                     cam_w_set,
    output logic [TUPLE_W-1:0]       cam_w_tag,
    output logic [ADDR_W-1:0]        cam_w_data,
    output logic                     cam_r_v,
    output logic [TUPLE_W-1:0]       cam_r_tag,
    input  logic [ADDR_W-1:0]        cam_r_data,
    input  logic                     cam_r_hit,
    output logic [15:0]              wr_grant_cnt
);

    localparam logic [3:0] STREAK_LIM = 4'(WR_STREAK_MAX);
    localparam logic [TABLE_ENTRIES-1:0] ONE_HOT0 = {{(TABLE_ENTRIES-1){1'b0}}, 1'b1};

    logic [1:0]          resp_val_q, resp_val_d;
    logic [1:0]          resp_hit_q, resp_hit_d;
    logic [2*ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic [3:0]          streak_q, streak_d;
    logic                rr_q, rr_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;

    logic [1:0] elig;
    logic       any_elig;
    logic       wr_gnt;
    logic [1:0] rd_gnt;
    logic       rd_idx;

    // A full buffer still counts as free when it drains this same cycle.
    always_comb begin
        elig     = rd_req_val & (~resp_val_q | rd_resp_rdy);
        any_elig = |elig;
        wr_gnt   = rst_n & wr_req_val & (~any_elig | (streak_q < STREAK_LIM));
        rd_gnt   = 2'b00;
        rd_idx   = rr_q;
        if (rst_n && !wr_gnt && any_elig) begin
            rd_idx         = elig[rr_q] ? rr_q : ~rr_q;
            rd_gnt[rd_idx] = 1'b1;
        end
    end

    always_comb begin
        rd_req_rdy = rd_gnt;
        wr_req_rdy = wr_gnt;
        cam_w_v    = wr_gnt ? (ONE_HOT0 << wr_req_entry) : '0;
        cam_w_set  = wr_req_set;
        cam_w_tag  = wr_req_tuple;
        cam_w_data = wr_req_addr;
        cam_r_v    = |rd_gnt;
        cam_r_tag  = '0;
        if (|rd_gnt) begin
            cam_r_tag = rd_req_tuple[rd_idx*TUPLE_W +: TUPLE_W];
        end
    end

    always_comb begin
        streak_d    = 4'd0;
        rr_d        = rr_q;
        wr_cnt_d    = wr_cnt_q;
        resp_val_d  = resp_val_q;
        resp_hit_d  = resp_hit_q;
        resp_addr_d = resp_addr_q;
        if (wr_gnt) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
            if (any_elig) begin
                streak_d = streak_q + 4'd1;
            end
        end
        if (|rd_gnt) begin
            rr_d = ~rd_idx;
        end
        for (int i = 0; i < 2; i++) begin
            if (rd_gnt[i]) begin
                resp_val_d[i]                    = 1'b1;
                resp_hit_d[i]                    = cam_r_hit;
                resp_addr_d[i*ADDR_W +: ADDR_W]  = cam_r_data;
            end else if (rd_resp_rdy[i]) begin
                resp_val_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_val_q  <= '0;
            resp_hit_q  <= '0;
            resp_addr_q <= '0;
            streak_q    <= '0;
            rr_q        <= 1'b0;
            wr_cnt_q    <= '0;
        end else begin
            resp_val_q  <= resp_val_d;
            resp_hit_q  <= resp_hit_d;
            resp_addr_q <= resp_addr_d;
            streak_q    <= streak_d;
            rr_q        <= rr_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign rd_resp_val  = resp_val_q;
    assign rd_resp_hit  = resp_hit_q;
    assign rd_resp_addr = resp_addr_q;
    assign wr_grant_cnt = wr_cnt_q;

endmodule

// File: doc/ip_rewrite_cam_arb.md
Name: ip_rewrite_cam_arb

Overview:
- Shares one flow-lookup CAM (1 read port, 1 write port, combinational read) among three requesters:
  - RX rewriter read (requester 0)
  - TX rewriter read (requester 1)
  - lookup table control write
- Grants at most one CAM access per cycle. Arbitrates reads round-robin and gives writes bounded priority.
- Registers read results into a per-requester response buffer with its own val/rdy handshake.
- Sits between both ip_rewrite datapaths, the lookup table controller, and the CAM instance.

Parameters:
- TABLE_ENTRIES, 8, number of CAM entries; must be a power of 2.
- TUPLE_W, 96, flow lookup tuple width.
- ADDR_W, 32, rewrite IP address width.
- WR_STREAK_MAX, 4, max consecutive write grants while any read is eligible (range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req_val  in  2  per-requester read request valid
- rd_req_tuple  in  2*TUPLE_W  lookup tuples; requester i occupies bits [i*TUPLE_W +: TUPLE_W]
- rd_req_rdy  out  2  read request accepted (grant)
- rd_resp_val  out  2  response buffer valid
- rd_resp_hit  out  2  response hit flag
- rd_resp_addr  out  2*ADDR_W  response rewrite address, packed like rd_req_tuple
- rd_resp_rdy  in  2  response consumed
- wr_req_val  in  1  write request valid
- wr_req_entry  in  $clog2(TABLE_ENTRIES)  entry index
- wr_req_set  in  1  1 = set entry, 0 = clear entry
- wr_req_tuple  in  TUPLE_W  tag
- wr_req_addr  in  ADDR_W  data
- wr_req_rdy  out  1  write accepted
- cam_w_v  out  TABLE_ENTRIES  one-hot write enable
- cam_w_set  out  1  set_not_clear
- cam_w_tag  out  TUPLE_W  write tag
- cam_w_data  out  ADDR_W  write data
- cam_r_v  out  1  read valid
- cam_r_tag  out  TUPLE_W  read tag
- cam_r_data  in  ADDR_W  read data, same cycle as cam_r_v
- cam_r_hit  in  1  read hit, same cycle as cam_r_v
- wr_grant_cnt  out  16  total writes granted, wraps modulo 2^16

Behaviour:
- Reset (async assert, sync release):
  - rd_resp_val = 0, rd_resp_hit = 0, rd_resp_addr = 0.
  - Write streak counter = 0; RR pointer = 0 (requester 0 has priority first); wr_grant_cnt = 0.
  - All grant and CAM strobes are combinational from state, and are 0 while rst_n is low.
- Read requester i is eligible when rd_req_val[i] = 1 and its buffer is free. Free means rd_resp_val[i] = 0, or rd_resp_val[i] = 1 and rd_resp_rdy[i] = 1 in the same cycle (pass-through drain).
- Grant decision, exactly one or none per cycle, all combinational:
  - Write granted if wr_req_val = 1 and (no read eligible, or streak < WR_STREAK_MAX).
  - Otherwise the eligible read nearest the RR pointer is granted.
- Write grant:
  - wr_req_rdy = 1; cam_w_v = 1 << wr_req_entry; set/tag/data driven from the request.
  - Streak increments if any read was eligible, else resets to 0.
  - wr_grant_cnt increments.
- Read grant to requester i:
  - rd_req_rdy[i] = 1; cam_r_v = 1; cam_r_tag = the tuple of requester i.
  - Next edge: buffer i loads cam_r_hit and cam_r_data; rd_resp_val[i] = 1.
  - RR pointer moves to the other requester; streak resets to 0.
  - Latency: request accepted in cycle N, response valid in cycle N+1.
- cam_r_v and any cam_w_v bit are never high in the same cycle.
- Ordering: a read granted the cycle after a write observes the written entry.
- Backpressure: response i holds (hit, addr) stable until rd_resp_rdy[i]. While buffer i is full and not draining, requester i is never granted.
- Idle cycle (no request): streak resets to 0; RR pointer holds.
- rd_req_rdy asserts only when the matching rd_req_val is high; wr_req_rdy asserts only when wr_req_val is high.
- rst_n asserted mid-operation: pending buffered responses are discarded; requesters must reissue.

Test Plan:
- Single read: req0 tuple T with an entry (T, 0x0A000001) set → rdy0 in cycle N; cycle N+1 val0 = 1, hit = 1, addr = 0x0A000001; requester 1 untouched.
- RR fairness: both reads held valid, resp_rdy = 1 constantly → grants alternate 0, 1, 0, 1 with one grant per cycle and no gaps.
- Write starvation bound: WR_STREAK_MAX = 4, continuous write plus read0 pending → 4 writes, 1 read, 4 writes; wr_grant_cnt = 8 after 10 cycles.
- Backpressure: resp_rdy0 = 0, req0 held → exactly one grant; resp held stable for 20 cycles; raising resp_rdy0 drains and a new grant occurs in the same cycle.
- Write-then-read: clear entry 3 holding T at cycle N, read T at N+1 → hit = 0. Then set entry 5 = (T, 0xC0A80002) → next read gets hit = 1, addr = 0xC0A80002; cam_w_v = 0x20.
- Mid-transaction reset: rst_n low with val0 = 1 → rd_resp_val = 0 immediately; after release the pointer favours requester 0 and streak = 0.
